sram_be_rmw_ctrl: RTL
=====================

// Module: sram_be_rmw_ctrl
// PURPOSE
//   Byte-enable front end placed directly upstream of the single-port SRAM wrapper.
//   The wrapper drives a full-width write mask, so this block provides byte enables.
//   A full-mask write or a read goes straight through. A partial-mask write becomes a
//   read-modify-write: one read cycle, then one merged write. Serves cache data, tag and
//   valid/dirty arrays.
// PARAMETERS
//   DATA_WIDTH  64  SRAM word width in bits (45/44 used for tag arrays)
//   ADDR_WIDTH  8   SRAM address width; depth = 2**ADDR_WIDTH
//   BE_WIDTH    (DATA_WIDTH+7)/8  derived, not overridden; lane i = bits [8i+7:8i], top lane clipped
// PORTS
//   Clk_CI      in   1           clock, all state on rising edge
//   Rst_RI      in   1           asynchronous, active-high reset
//   ReqValid_SI in   1           request valid
//   ReqReady_SO out  1           request accepted when ReqValid_SI & ReqReady_SO
//   ReqWe_SI    in   1           1 = write, 0 = read
//   ReqBe_SI    in   BE_WIDTH    byte enables (writes only)
//   ReqAddr_DI  in   ADDR_WIDTH  word address
//   ReqData_DI  in   DATA_WIDTH  write data
//   RspValid_SO out  1           read data valid, one-cycle pulse
//   RspData_DO  out  DATA_WIDTH  read data, meaningful only while RspValid_SO=1
//   CSel_SO     out  1           to SRAM CSel_SI
//   WrEn_SO     out  1           to SRAM WrEn_SI
//   Addr_DO     out  ADDR_WIDTH  to SRAM Addr_DI
//   WrData_DO   out  DATA_WIDTH  to SRAM WrData_DI
//   RdData_DI   in   DATA_WIDTH  from SRAM RdData_DO; valid the cycle after a read strobe
// BEHAVIOUR
//   - Reset: state=IDLE; RspValid_SO=0; captured addr/be/data cleared to 0.
//     ReqReady_SO=1 while reset is deasserted in IDLE.
//   - FSM states: IDLE, MERGE.
//     ReqReady_SO = (state==IDLE). The SRAM strobes are combinational from the accepted
//     request in IDLE and from the captured request in MERGE.
//   - IDLE, read accepted: CSel=1, WrEn=0, Addr=ReqAddr. Next cycle RspValid_SO=1 and
//     RspData_DO=RdData_DI.
//     Reads sustain one per cycle. Latency is fixed at 1.
//   - IDLE, write with ReqBe all ones: CSel=1, WrEn=1, WrData=ReqData. Stay in IDLE.
//     No response is produced.
//   - IDLE, write with ReqBe==0: accepted, no SRAM access (CSel=0), no response.
//   - IDLE, partial write (mask nonzero, not all ones):
//     - Read strobe to ReqAddr.
//     - Capture addr/be/data.
//     - Go to MERGE.
//   - MERGE:
//     - CSel=1, WrEn=1, Addr=addr_q.
//     - WrData lane i = be_q[i] ? data_q lane i : RdData_DI lane i.
//     - ReqReady_SO=0, RspValid_SO=0.
//     - Return to IDLE next cycle.
//     A partial write therefore occupies 2 cycles; throughput drops 1 cycle per partial write.
//   - No strobe is issued when ReqValid_SI=0 in IDLE. CSel_SO=0 and WrEn_SO=0 in that case.
//   - Hazards: the RMW completes before any new request is accepted. A read of the same
//     address accepted the cycle after MERGE returns the merged data. No forwarding is
//     needed.
//   - Reset asserted in MERGE: the merged write is suppressed immediately, because
//     CSel_SO=0 during reset. The SRAM keeps its old contents. The FSM returns to IDLE.
//   - ReqValid_SI held while ReqReady_SO=0: the request is not consumed, and its fields
//     must stay stable (upstream rule).
// STRUCTURE
//   - Shared package sram_ctrl_pkg: the state enum {IDLE, MERGE} and the function
//     be_merge(old, new, be). The same function is reused by the other array controllers.
//   - Single module, no sub-modules. The SRAM wrapper is instantiated by the parent, not here.
// TESTING (DATA_WIDTH=64, ADDR_WIDTH=8)
//   1. Reset with random inputs -> RspValid_SO=0, CSel_SO=0 throughout reset; ReqReady_SO=1
//      after release.
//   2. Write addr 0x10, data 0x0123456789ABCDEF, BE 0xFF -> one cycle CSel=WrEn=1.
//      A read of 0x10 returns 0x0123456789ABCDEF with RspValid one cycle later.
//   3. Continue from 2: write 0x10, data all-F, BE 0x0F:
//      - cycle 0: read strobe;
//      - cycle 1: ReqReady=0 and WrData=0x01234567FFFFFFFF;
//      - a read at cycle 2 returns 0x01234567FFFFFFFF.
//   4. Reads of addr 1,2,3 on consecutive cycles -> RspValid high 3 consecutive cycles
//      with data in order.
//   5. Write with BE 0x00 -> accepted, CSel never asserted, memory unchanged.
//   6. Partial write BE 0x80 to 0x10, with Rst_RI pulsed during MERGE -> no write strobe.
//      After reset, a read of 0x10 returns the pre-write value.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM array controllers: FSM state codes and the
// byte-lane merge used by every read-modify-write front end.
package sram_ctrl_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t MERGE = 1'b1;

    // Widest array any controller serves; narrower callers zero-extend and truncate.
    localparam int unsigned MAX_DATA_WIDTH = 128;
    localparam int unsigned MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

    typedef logic [MAX_DATA_WIDTH-1:0] word_t;
    typedef logic [MAX_BE_WIDTH-1:0]   be_t;

    function automatic word_t be_merge(word_t old_data, word_t new_data, be_t be);
        word_t merged;
        for (int i = 0; i < int'(MAX_BE_WIDTH); i++) begin
            merged[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_be_rmw_ctrl.sv
// Byte-enable front end for a full-mask single-port SRAM: full writes and reads pass
// straight through, partial writes become a read followed by one merged write.
module sram_be_rmw_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 8,
    localparam int unsigned BE_WIDTH  = (DATA_WIDTH + 7) / 8
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  ReqValid_SI,
    output logic                  ReqReady_SO,
    input  logic                  ReqWe_SI,
    input  logic [BE_WIDTH-1:0]   ReqBe_SI,
    input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
    input  logic [DATA_WIDTH-1:0] ReqData_DI,
    output logic                  RspValid_SO,
    output logic [DATA_WIDTH-1:0] RspData_DO,
    output logic                  CSel_SO,
    output logic                  WrEn_SO,
    output logic [ADDR_WIDTH-1:0] Addr_DO,
    output logic [DATA_WIDTH-1:0] WrData_DO,
    input  logic [DATA_WIDTH-1:0] RdData_DI
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  capture;
    logic                  csel, wr_en;
    logic                  be_full, be_any;

    assign be_full = (ReqBe_SI == {BE_WIDTH{1'b1}});
    assign be_any  = |ReqBe_SI;

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        capture     = 1'b0;
        csel        = 1'b0;
        wr_en       = 1'b0;
        Addr_DO     = ReqAddr_DI;
        WrData_DO   = ReqData_DI;
        case (state_q)
            IDLE: begin
                if (ReqValid_SI) begin
                    if (!ReqWe_SI) begin
                        csel        = 1'b1;
                        rsp_valid_d = 1'b1;
                    end else if (be_full) begin
                        csel  = 1'b1;
                        wr_en = 1'b1;
                    end else if (be_any) begin
                        // Fetch the old word; the merge happens next cycle.
                        csel    = 1'b1;
                        capture = 1'b1;
                        state_d = MERGE;
                    end
                end
            end
            MERGE: begin
                csel      = 1'b1;
                wr_en     = 1'b1;
                Addr_DO   = addr_q;
                WrData_DO = DATA_WIDTH'(be_merge(word_t'(RdData_DI), word_t'(data_q),
                                                 be_t'(be_q)));
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating with reset drops an in-flight merged write the moment reset rises.
    assign CSel_SO     = csel & ~Rst_RI;
    assign WrEn_SO     = wr_en & ~Rst_RI;
    assign ReqReady_SO = (state_q == IDLE);
    assign RspValid_SO = rsp_valid_q;
    assign RspData_DO  = RdData_DI;

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            if (capture) begin
                addr_q <= ReqAddr_DI;
                be_q   <= ReqBe_SI;
                data_q <= ReqData_DI;
            end
        end
    end

endmodule
